reduce_accum: RTL and testbench

Sequential, parametrised N-bit reduction unit: reduces each accepted N-bit word to one bit with a selectable operator (OR, AND, XOR, NOR) and accumulates across a frame of BEATS words. It emits one result bit per frame over a valid/ready handshake. It sits between a word-stream producer and any consumer of a frame-level flag, such as any-set, all-set or parity checks.

---
 rtl/reduce_pkg.sv | 8 +
 rtl/reduce_vec.sv | 12 +
 rtl/reduce_accum.sv | 64 ++++++
 tb/tb_reduce_accum.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// reduce_pkg: operator codes and FSM state encoding shared by the reduction unit.
package reduce_pkg;
    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;
    localparam logic [1:0] MODE_NOR = 2'b11;
    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} state_t;
endpackage

// File: rtl/reduce_vec.sv
// reduce_vec: combinational reduction of an N-bit word to one bit; NOR reduces as OR.
module reduce_vec import reduce_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [1:0]   mode,
    output logic         red
);
    always_comb begin
        red = mode == MODE_AND ? &x : mode == MODE_XOR ? ^x : |x;
    end
endmodule

// File: rtl/reduce_accum.sv
// reduce_accum: accumulates per-word reductions over a frame of BEATS words and
// hands out one result bit per frame over valid/ready.
module reduce_accum import reduce_pkg::*; #(
    parameter int N     = 4,
    parameter int BEATS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic [N-1:0] x,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         res,
    output logic         res_valid,
    input  logic         res_ready
);
    localparam int CW = $clog2(BEATS + 1);
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_inc;
    logic [1:0]    mode_q, red_mode;
    logic          acc, acc_op, red, accept, last;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt + 1'b1;
    // The first beat reduces with the live mode; later beats use the latched one.
    assign red_mode = state == ST_IDLE ? mode : mode_q;
    assign last     = (state == ST_IDLE && BEATS == 1) || (state == ST_ACC && cnt_inc == CW'(BEATS));
    assign acc_op   = mode_q == MODE_AND ? acc & red : mode_q == MODE_XOR ? acc ^ red : acc | red;
    reduce_vec #(.N(N)) u_red (
        .x    (x),
        .mode (red_mode),
        .red  (red)
    );
    always_comb begin
        state_n = state;
        if (state == ST_DONE)
            state_n = res_ready ? ST_IDLE : ST_DONE;
        else if (accept)
            state_n = last ? ST_DONE : ST_ACC;
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= 1'b0;
            cnt    <= '0;
            mode_q <= MODE_OR;
        end else if (accept) begin
            acc <= state == ST_IDLE ? red : acc_op;
            cnt <= state == ST_IDLE ? CW'(1) : cnt_inc;
            if (state == ST_IDLE)
                mode_q <= mode;
        end else if (state == ST_DONE && res_ready) begin
            cnt <= '0;
        end
    end
    // NOR is applied once to the whole-frame OR at the output.
    assign in_ready  = state != ST_DONE;
    assign res_valid = state == ST_DONE;
    assign res       = res_valid & (acc ^ (mode_q == MODE_NOR));
endmodule

// File: tb/tb_reduce_accum.sv
// tb_reduce_accum: table vectors, corner sequences and random frames checked against a frame-level model.
module tb_reduce_accum;
    logic       clk, rst;
    logic [1:0] mode, mode1;
    logic [3:0] x, x1;
    logic       in_valid, in_ready, res, res_valid, res_ready;
    logic       in_valid1, in_ready1, res1, res_valid1, res_ready1;
    int         tests = 0;
    int         fails = 0;

    reduce_accum #(.N(4), .BEATS(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .x(x), .in_valid(in_valid), .in_ready(in_ready),
        .res(res), .res_valid(res_valid), .res_ready(res_ready)
    );
    reduce_accum #(.N(4), .BEATS(1)) dut1 (
        .clk(clk), .rst(rst), .mode(mode1), .x(x1), .in_valid(in_valid1), .in_ready(in_ready1),
        .res(res1), .res_valid(res_valid1), .res_ready(res_ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  mode;
        logic [1:0]  mode_later;
        logic [15:0] words;
        logic        expect_res;
    } vec_t;

    // Frame result from the operator's meaning over all frame bits.
    function automatic logic model(input logic [1:0] m, input logic [15:0] w);
        case (m)
            2'b00:   return w != 16'h0;
            2'b01:   return w == 16'hffff;
            2'b10:   return ^w;
            default: return w == 16'h0;
        endcase
    endfunction

    function automatic logic model1(input logic [1:0] m, input logic [3:0] w);
        return model(m, m == 2'b01 ? {12'hfff, w} : {12'h000, w});
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string nm, input logic [1:0] m, input logic [1:0] ml,
                             input logic [15:0] w, input logic exp, input int gaps, input int hold);
        for (int i = 0; i < 4; i++) begin
            if (gaps > 0) begin
                repeat ($urandom_range(0, gaps)) begin
                    in_valid = 1'b0;
                    x = 4'($urandom);
                    mode = 2'($urandom);
                    tick();
                    chk({nm, "_gap_rv"}, {7'b0, res_valid}, 8'd0);
                end
            end
            mode = i == 0 ? m : ml;
            x = w[i*4 +: 4];
            in_valid = 1'b1;
            chk({nm, "_beat_ready"}, {6'b0, in_ready, res_valid}, 8'b10);
            tick();
        end
        in_valid = 1'b0;
        chk({nm, "_rv"}, {7'b0, res_valid}, 8'd1);
        chk({nm, "_res"}, {7'b0, res}, {7'b0, exp});
        repeat (hold) begin
            in_valid = 1'b1;
            x = 4'hf;
            res_ready = 1'b0;
            tick();
            chk({nm, "_hold"}, {5'b0, in_ready, res_valid, res}, {5'b0, 1'b0, 1'b1, exp});
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({nm, "_idle"}, {6'b0, in_ready, res_valid}, 8'b10);
    endtask

    vec_t        vecs[6];
    logic [15:0] w;
    logic [1:0]  m;
    logic        exp_r;

    initial begin
        vecs[0] = '{"or_zero",  2'b00, 2'b00, 16'h0000, 1'b0};
        vecs[1] = '{"or_one",   2'b00, 2'b00, 16'h00a0, 1'b1};
        vecs[2] = '{"and_all",  2'b01, 2'b01, 16'hffff, 1'b1};
        vecs[3] = '{"and_hole", 2'b01, 2'b01, 16'hffef, 1'b0};
        vecs[4] = '{"nor_zero", 2'b11, 2'b11, 16'h0000, 1'b1};
        vecs[5] = '{"xor_chg",  2'b10, 2'b01, 16'h871a, 1'b1};
        rst = 1'b1; mode = 2'b00; x = 4'h0; in_valid = 1'b0; res_ready = 1'b0;
        mode1 = 2'b00; x1 = 4'h0; in_valid1 = 1'b0; res_ready1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset", {5'b0, in_ready, res_valid, res}, 8'b100);
        chk("reset1", {5'b0, in_ready1, res_valid1, res1}, 8'b100);

        foreach (vecs[i])
            run_frame(vecs[i].name, vecs[i].mode, vecs[i].mode_later, vecs[i].words, vecs[i].expect_res, 0, 0);

        run_frame("bp", 2'b00, 2'b00, 16'h0f00, 1'b1, 0, 3);
        run_frame("bp_next", 2'b10, 2'b10, 16'h0001, 1'b1, 0, 0);

        // Reset after two AND beats of zero must leave no residue.
        mode = 2'b01; x = 4'h0; in_valid = 1'b1;
        tick();
        tick();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_mid", {5'b0, in_ready, res_valid, res}, 8'b100);
        run_frame("rst_follow", 2'b01, 2'b01, 16'hffff, 1'b1, 0, 0);

        // Reset while a result is pending drops it.
        mode = 2'b00; x = 4'hf; in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        chk("rst_done_pre", {6'b0, res_valid, res}, 8'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_done", {5'b0, in_ready, res_valid, res}, 8'b100);

        for (int k = 0; k < 40; k++) begin
            m = 2'($urandom);
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 2))
                    0:       w[i*4 +: 4] = 4'h0;
                    1:       w[i*4 +: 4] = 4'hf;
                    default: w[i*4 +: 4] = 4'($urandom);
                endcase
            end
            exp_r = model(m, w);
            run_frame("rand", m, 2'($urandom), w, exp_r, 2, int'($urandom_range(0, 3)));
        end

        // BEATS=1: back-to-back words yield a result every second cycle.
        in_valid1 = 1'b1;
        res_ready1 = 1'b1;
        for (int k = 0; k < 12; k++) begin
            mode1 = k == 0 ? 2'b10 : 2'($urandom);
            x1 = k == 0 ? 4'b0111 : 4'($urandom);
            exp_r = model1(mode1, x1);
            tick();
            if (k % 2 == 0)
                chk("b1_res", {5'b0, in_ready1, res_valid1, res1}, {5'b0, 1'b0, 1'b1, exp_r});
            else
                chk("b1_idle", {6'b0, in_ready1, res_valid1}, 8'b10);
        end
        in_valid1 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
